// File: rtl/urv_load_writeback_if.sv
// X/W-stage bundle between execute, data memory and writeback, plus the register-file write port.
// The slave modport is the writeback stage; the master modport is the upstream pipeline and memory side.
interface urv_load_writeback_if;
  logic [2:0]  w_fun_i;
  logic        w_load_i;
  logic        w_store_i;
  logic        w_valid_i;
  logic [4:0]  w_rd_i;
  logic [31:0] w_rd_value_i;
  logic        w_rd_write_i;
  logic [31:0] w_dm_addr_i;
  logic [1:0]  w_rd_source_i;
  logic [31:0] w_rd_shifter_i;
  logic [31:0] w_rd_multiply_i;
  logic [31:0] dm_data_l_i;
  logic        dm_load_done_i;
  logic        dm_store_done_i;
  logic        w_stall_req_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_rd_value_o;
  logic        rf_rd_write_o;
  logic        w_bus_error_o;

  modport master (
    output w_fun_i, w_load_i, w_store_i, w_valid_i, w_rd_i, w_rd_value_i, w_rd_write_i,
           w_dm_addr_i, w_rd_source_i, w_rd_shifter_i, w_rd_multiply_i,
           dm_data_l_i, dm_load_done_i, dm_store_done_i,
    input  w_stall_req_o, rf_rd_o, rf_rd_value_o, rf_rd_write_o, w_bus_error_o
  );

  modport slave (
    input  w_fun_i, w_load_i, w_store_i, w_valid_i, w_rd_i, w_rd_value_i, w_rd_write_i,
           w_dm_addr_i, w_rd_source_i, w_rd_shifter_i, w_rd_multiply_i,
           dm_data_l_i, dm_load_done_i, dm_store_done_i,
    output w_stall_req_o, rf_rd_o, rf_rd_value_o, rf_rd_write_o, w_bus_error_o
  );
endinterface

// File: rtl/urv_load_writeback.sv
// Writeback stage: waits for data-memory completion, aligns load data, drives the register-file write port.
// Latency: RF write one cycle after completion; backpressure: combinational stall until done or timeout abort.
module urv_load_writeback #(
  parameter int unsigned g_timeout = 255
) (
  input logic           clk_i,
  input logic           rst_i,
  urv_load_writeback_if.slave wb
);

  localparam logic [7:0] TIMEOUT = 8'(g_timeout);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic        mem_op;
  logic        done;
  logic        timeout;
  logic        complete;
  logic        commit;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] wr_val;
  logic        unused_addr;

  assign unused_addr = ^wb.w_dm_addr_i[31:2];

  assign mem_op  = (wb.w_load_i | wb.w_store_i) & wb.w_valid_i;
  assign done    = wb.w_load_i ? wb.dm_load_done_i : wb.dm_store_done_i;
  // A completion strobe in the last allowed cycle still wins over the abort.
  assign timeout = (state == ST_WAIT) && !done && (cnt == TIMEOUT);

  always_comb begin
    complete = 1'b0;
    case (state)
      ST_IDLE: complete = !mem_op || done;
      ST_WAIT: complete = done;
      default: complete = 1'b0;
    endcase
  end

  assign commit = complete & wb.w_valid_i & (wb.w_load_i | (wb.w_rd_write_i & ~wb.w_store_i))
                & (wb.w_rd_i != 5'd0);

  // Gated by reset so an in-flight access releases the pipeline the moment reset hits.
  assign wb.w_stall_req_o = !rst_i &&
                            (((state == ST_IDLE) && mem_op && !done) ||
                             ((state == ST_WAIT) && !done && !timeout));

  always_comb begin
    lane_b = 8'h00;
    case (wb.w_dm_addr_i[1:0])
      2'd0: lane_b = wb.dm_data_l_i[7:0];
      2'd1: lane_b = wb.dm_data_l_i[15:8];
      2'd2: lane_b = wb.dm_data_l_i[23:16];
      2'd3: lane_b = wb.dm_data_l_i[31:24];
      default: lane_b = 8'h00;
    endcase
    lane_h = wb.w_dm_addr_i[1] ? wb.dm_data_l_i[31:16] : wb.dm_data_l_i[15:0];

    load_val = wb.dm_data_l_i;
    case (wb.w_fun_i)
      3'b000: load_val = {{24{lane_b[7]}}, lane_b};
      3'b100: load_val = {24'h000000, lane_b};
      3'b001: load_val = {{16{lane_h[15]}}, lane_h};
      3'b101: load_val = {16'h0000, lane_h};
      default: load_val = wb.dm_data_l_i;
    endcase

    wr_val = wb.w_rd_value_i;
    if (wb.w_load_i) begin
      wr_val = load_val;
    end else begin
      case (wb.w_rd_source_i)
        2'b01:   wr_val = wb.w_rd_shifter_i;
        2'b10:   wr_val = wb.w_rd_multiply_i;
        default: wr_val = wb.w_rd_value_i;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= ST_IDLE;
      cnt              <= 8'd0;
      wb.rf_rd_write_o <= 1'b0;
      wb.rf_rd_o       <= 5'd0;
      wb.rf_rd_value_o <= 32'd0;
      wb.w_bus_error_o <= 1'b0;
    end else begin
      wb.rf_rd_write_o <= commit;
      wb.w_bus_error_o <= timeout;
      if (commit) begin
        wb.rf_rd_o       <= wb.w_rd_i;
        wb.rf_rd_value_o <= wr_val;
      end
      case (state)
        ST_IDLE: begin
          if (mem_op && !done) begin
            state <= ST_WAIT;
            cnt   <= 8'd1;
          end
        end
        ST_WAIT: begin
          if (done || timeout) begin
            state <= ST_IDLE;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_urv_load_writeback.sv
// Randomized bench for urv_load_writeback against a transaction-level model of completion timing and load alignment.
module tb_urv_load_writeback;

  localparam int TO = 4;

  typedef struct {
    logic [2:0]  fun;
    logic        ld, st, vld, rdw;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [31:0] val, addr, sh, mul, ldata;
    int          d;
  } instr_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   stall_cnt, wr_cnt, err_cnt;
  logic [4:0]  last_rd;
  logic [31:0] last_val;
  logic        exp_stall, exp_wr, exp_err;
  logic [4:0]  exp_rd;
  logic [31:0] exp_val;
  logic        pend_wr, pend_err;
  logic [4:0]  pend_rd;
  logic [31:0] pend_val;

  urv_load_writeback_if bus();

  urv_load_writeback #(.g_timeout(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference load alignment, written as shift-and-mask arithmetic on the little-endian word.
  function automatic logic [31:0] m_load(input logic [31:0] d, input logic [31:0] a, input logic [2:0] f);
    logic [31:0] v;
    int sh;
    v = d;
    if (f == 3'b000 || f == 3'b100) begin
      sh = 8 * int'(a[1:0]);
      v = (d >> sh) & 32'h0000_00FF;
      if (f == 3'b000 && v >= 32'd128) v = v - 32'd256;
    end else if (f == 3'b001 || f == 3'b101) begin
      sh = 16 * int'(a[1]);
      v = (d >> sh) & 32'h0000_FFFF;
      if (f == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_result(input instr_t t);
    if (t.ld) return m_load(t.ldata, t.addr, t.fun);
    if (t.src == 2'b01) return t.sh;
    if (t.src == 2'b10) return t.mul;
    return t.val;
  endfunction

  function automatic instr_t mk(input logic [2:0] fun, input logic ld, input logic st, input logic [4:0] rd,
                                input logic [31:0] val, input logic [31:0] addr, input logic [31:0] ldata,
                                input int d);
    instr_t t;
    t.fun = fun; t.ld = ld; t.st = st; t.vld = 1'b1; t.rdw = !ld; t.rd = rd;
    t.src = 2'b00; t.val = val; t.addr = addr; t.sh = 32'hA5A5_0001; t.mul = 32'h5A5A_0002;
    t.ldata = ldata; t.d = d;
    return t;
  endfunction

  task automatic drive_cycle(input instr_t t, input int k);
    logic mem;
    mem = (t.ld || t.st) && t.vld;
    bus.w_fun_i = t.fun;             bus.w_load_i = t.ld;        bus.w_store_i = t.st;
    bus.w_valid_i = t.vld;           bus.w_rd_i = t.rd;          bus.w_rd_value_i = t.val;
    bus.w_rd_write_i = t.rdw;        bus.w_dm_addr_i = t.addr;   bus.w_rd_source_i = t.src;
    bus.w_rd_shifter_i = t.sh;       bus.w_rd_multiply_i = t.mul;
    // The strobe that does not belong to the current op is noise the stage must ignore.
    bus.dm_load_done_i  = (mem && t.ld) ? (k == t.d) : 1'($urandom);
    bus.dm_store_done_i = (mem && t.st) ? (k == t.d) : 1'($urandom);
    bus.dm_data_l_i     = (k == t.d) ? t.ldata : $urandom;
  endtask

  task automatic compare_cycle();
    chk("stall", 32'(bus.w_stall_req_o), 32'(exp_stall));
    chk("rf_write", 32'(bus.rf_rd_write_o), 32'(exp_wr));
    if (exp_wr) begin
      chk("rf_rd", 32'(bus.rf_rd_o), 32'(exp_rd));
      chk("rf_value", bus.rf_rd_value_o, exp_val);
    end
    chk("bus_error", 32'(bus.w_bus_error_o), 32'(exp_err));
    if (bus.w_stall_req_o) stall_cnt++;
    if (bus.w_bus_error_o) err_cnt++;
    if (bus.rf_rd_write_o) begin
      wr_cnt++;
      last_rd = bus.rf_rd_o;
      last_val = bus.rf_rd_value_o;
    end
  endtask

  // One instruction: stalls until its strobe or the timeout, then commits/aborts; effects show one cycle later.
  task automatic run_instr(input instr_t t);
    logic mem, ok;
    int k_end;
    mem = (t.ld || t.st) && t.vld;
    ok = !mem || (t.d <= TO);
    k_end = !mem ? 0 : ((t.d < TO) ? t.d : TO);
    for (int k = 0; k <= k_end; k++) begin
      drive_cycle(t, k);
      exp_stall = mem && (k < k_end);
      exp_wr = pend_wr; exp_rd = pend_rd; exp_val = pend_val; exp_err = pend_err;
      pend_wr = 1'b0; pend_err = 1'b0;
      if (k == k_end) begin
        pend_wr  = ok && t.vld && (t.ld || (t.rdw && !t.st)) && (t.rd != 5'd0);
        pend_rd  = t.rd;
        pend_val = m_result(t);
        pend_err = mem && !ok;
      end
      @(negedge clk);
      compare_cycle();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic directed(input string nm, input instr_t t, input int e_stall, input int e_wr,
                          input int e_err, input logic [31:0] e_val);
    instr_t idle;
    int s0, w0, e0;
    idle = mk(3'b000, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 0);
    idle.vld = 1'b0;
    s0 = stall_cnt; w0 = wr_cnt; e0 = err_cnt;
    run_instr(t);
    run_instr(idle);
    chk({nm, "_stall_cycles"}, 32'(stall_cnt - s0), 32'(e_stall));
    chk({nm, "_writes"}, 32'(wr_cnt - w0), 32'(e_wr));
    chk({nm, "_errors"}, 32'(err_cnt - e0), 32'(e_err));
    if (e_wr != 0) begin
      chk({nm, "_rd"}, 32'(last_rd), 32'(t.rd));
      chk({nm, "_value"}, last_val, e_val);
    end
  endtask

  initial begin
    instr_t t;
    int kind;
    checks = 0; failures = 0; stall_cnt = 0; wr_cnt = 0; err_cnt = 0;
    last_rd = '0; last_val = '0;
    pend_wr = 1'b0; pend_err = 1'b0; pend_rd = '0; pend_val = '0;
    t = mk(3'b000, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 0);
    t.vld = 1'b0;
    drive_cycle(t, 1);
    bus.dm_load_done_i = 1'b0; bus.dm_store_done_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_stall", 32'(bus.w_stall_req_o), 32'd0);
    chk("reset_rf_write", 32'(bus.rf_rd_write_o), 32'd0);
    chk("reset_rf_rd", 32'(bus.rf_rd_o), 32'd0);
    chk("reset_rf_value", bus.rf_rd_value_o, 32'd0);
    chk("reset_bus_error", 32'(bus.w_bus_error_o), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    directed("alu", mk(3'b000, 1'b0, 1'b0, 5'd5, 32'h1234_5678, 32'h0, 32'h0, 0), 0, 1, 0, 32'h1234_5678);
    directed("ld_b", mk(3'b000, 1'b1, 1'b0, 5'd7, 32'h0, 32'h0000_1003, 32'h80FF_0011, 3), 3, 1, 0, 32'hFFFF_FF80);
    directed("ld_bu", mk(3'b100, 1'b1, 1'b0, 5'd7, 32'h0, 32'h0000_1003, 32'h80FF_0011, 3), 3, 1, 0, 32'h0000_0080);
    directed("ld_hu", mk(3'b101, 1'b1, 1'b0, 5'd9, 32'h0, 32'h0000_2002, 32'hBEEF_0000, 0), 0, 1, 0, 32'h0000_BEEF);
    t = mk(3'b010, 1'b0, 1'b1, 5'd4, 32'h1111_2222, 32'h0000_3000, 32'h0, 2);
    t.rdw = 1'b1;
    directed("store", t, 2, 0, 0, 32'h0);
    directed("timeout", mk(3'b010, 1'b1, 1'b0, 5'd6, 32'h0, 32'h0000_4000, 32'h0, TO + 2), TO, 0, 1, 32'h0);
    directed("ld_at_limit", mk(3'b001, 1'b1, 1'b0, 5'd8, 32'h0, 32'h0, 32'h0000_8001, TO), TO, 1, 0, 32'hFFFF_8001);
    directed("ld_rd0", mk(3'b010, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0000_5000, 32'hDEAD_BEEF, 1), 1, 0, 0, 32'h0);

    // Reset while a load is stuck waiting.
    t = mk(3'b010, 1'b1, 1'b0, 5'd3, 32'h0, 32'h0000_6000, 32'h0, 1000);
    for (int k = 0; k < 2; k++) begin
      drive_cycle(t, k);
      exp_stall = 1'b1; exp_wr = 1'b0; exp_err = 1'b0; exp_rd = '0; exp_val = '0;
      @(negedge clk);
      compare_cycle();
      @(posedge clk);
      #1;
    end
    drive_cycle(t, 2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midwait_rst_stall", 32'(bus.w_stall_req_o), 32'd0);
    chk("midwait_rst_rf_write", 32'(bus.rf_rd_write_o), 32'd0);
    chk("midwait_rst_rf_rd", 32'(bus.rf_rd_o), 32'd0);
    chk("midwait_rst_rf_value", bus.rf_rd_value_o, 32'd0);
    chk("midwait_rst_bus_error", 32'(bus.w_bus_error_o), 32'd0);
    @(posedge clk);
    #1;
    t.vld = 1'b0; t.ld = 1'b0;
    drive_cycle(t, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    pend_wr = 1'b0; pend_err = 1'b0;

    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 3);
      t.vld   = ($urandom_range(0, 9) != 0);
      t.ld    = (kind == 2);
      t.st    = (kind == 3);
      t.rdw   = 1'($urandom);
      t.rd    = 5'($urandom);
      t.src   = 2'($urandom);
      t.fun   = 3'($urandom);
      t.val   = $urandom; t.sh = $urandom; t.mul = $urandom; t.ldata = $urandom;
      t.addr  = $urandom;
      if (t.fun == 3'b001 || t.fun == 3'b101) t.addr[0] = 1'b0;
      if (t.fun == 3'b010) t.addr[1:0] = 2'b00;
      t.d     = $urandom_range(0, TO + 2);
      run_instr(t);
    end
    t.vld = 1'b0; t.ld = 1'b0; t.st = 1'b0;
    run_instr(t);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
